serial_subtractor: RTL

- Bit-serial, multi-cycle subtractor. Computes Diff = A - B - Bin, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow.
- Counterpart to the team's combinational ripple adder. Serves as the area-lean arithmetic block in the datapath exercises.
- Start/busy/done handshake toward the controlling FSM.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//     - DEFAULT_WIDTH : default operand/result width
//     - state_t       : controller state encoding (IDLE=0, SHIFT=1, DONE=2)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit combinational full subtractor: d = a - b - bin.
//   Ports:
//     a, b  : operand bits
//     bin   : borrow in
//     d     : difference bit
//     bout  : borrow out (set when a < b + bin)
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing Diff = A - B - Bin, LSB first, one bit per
//   clock through a single full-subtractor cell and a registered borrow.
//   Start is accepted only in IDLE; busy is high for WIDTH cycles of SHIFT,
//   then done pulses for one cycle. Diff/Bout update only on SHIFT->DONE.
//
//   Parameters:
//     WIDTH : operand/result width (2..16)
//     CNT_W : bit counter width (derived)
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous active-high reset
//     start  : request, sampled in IDLE only
//     A, B   : minuend / subtrahend, captured on accepted start
//     Bin    : borrow in, captured on accepted start
//     Diff   : registered difference
//     Bout   : registered borrow out (1 = unsigned A < B + Bin)
//     busy   : high while shifting
//     done   : one-cycle completion pulse
//     Ovf    : two's-complement overflow, only when SERIAL_SUB_OVF_EN is
//              defined
//
//   Build option: define SERIAL_SUB_OVF_EN to add the Ovf output and the
//   operand sign-capture flops it needs.
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             Ovf
`endif
);

   state_t           state_q;
   logic [WIDTH-1:0] ra_q;
   logic [WIDTH-1:0] rb_q;
   logic [WIDTH-1:0] rd_q;
   logic [WIDTH-1:0] rd_d;
   logic [WIDTH-1:0] diff_q;
   logic [CNT_W-1:0] cnt_q;
   logic             br_q;
   logic             br_d;
   logic             d_bit;
   logic             bout_q;
   logic             busy_q;
   logic             done_q;
   logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_sgn_q;
   logic             b_sgn_q;
   logic             ovf_q;
`endif

   full_subtractor u_fs (
      .a    (ra_q[0]),
      .b    (rb_q[0]),
      .bin  (br_q),
      .d    (d_bit),
      .bout (br_d)
   );

   // New difference bit enters at the MSB; after WIDTH shifts bit 0 of the
   // result has reached position 0.
   assign rd_d     = {d_bit, rd_q[WIDTH-1:1]};
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         rd_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_sgn_q <= 1'b0;
         b_sgn_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  ra_q    <= A;
                  rb_q    <= B;
                  br_q    <= Bin;
                  rd_q    <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  a_sgn_q <= A[WIDTH-1];
                  b_sgn_q <= B[WIDTH-1];
`endif
               end
            end
            S_SHIFT: begin
               ra_q  <= ra_q >> 1;
               rb_q  <= rb_q >> 1;
               rd_q  <= rd_d;
               br_q  <= br_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  diff_q  <= rd_d;
                  bout_q  <= br_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                  // Overflow: operand signs differ and the result sign
                  // disagrees with the minuend.
                  ovf_q <= (a_sgn_q != b_sgn_q) && (rd_d[WIDTH-1] != a_sgn_q);
`endif
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Diff = diff_q;
   assign Bout = bout_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
   assign Ovf  = ovf_q;
`endif

endmodule
